// File: rtl/decode_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, flush and occupancy.
// Latency: none (wiring only).
// Backpressure: inst_ready throttles fetch; dec_ready holds the head entry.
interface decode_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_inst;
    logic [31:0]   dec_pc;
    logic [11:0]   dec_ctrl;
    logic          dec_invalid;
    logic [CW-1:0] count;

    modport master (
        output flush, inst_valid, inst, inst_pc, dec_ready,
        input  inst_ready, dec_valid, dec_inst, dec_pc, dec_ctrl, dec_invalid, count
    );

    modport slave (
        input  flush, inst_valid, inst, inst_pc, dec_ready,
        output inst_ready, dec_valid, dec_inst, dec_pc, dec_ctrl, dec_invalid, count
    );
endinterface

// File: rtl/decode_queue.sv
// MIPS main decoder in front of a DEPTH-entry FIFO; decoded at enqueue, presented in order.
// Latency: 1 cycle push-to-head, no bypass when empty.
// Backpressure: inst_ready = !full (a same-cycle pop does not free a slot); flush wins over all.
module decode_queue #(
    parameter int DEPTH       = 4,
    parameter bit ENABLE_CP0  = 1'b1,
    parameter bit ENABLE_HILO = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // {memtoreg,memwrite,branch,alusrc,regdst[1:0],regwrite,jump,hilo_write,jr,jal,cp0_write}
    localparam logic [11:0] C_RALU  = 12'b0000_01_100000;
    localparam logic [11:0] C_HILO  = 12'b0000_00_001000;
    localparam logic [11:0] C_JR    = 12'b0000_00_000100;
    localparam logic [11:0] C_JALR  = 12'b0000_01_100110;
    localparam logic [11:0] C_IALU  = 12'b0001_00_100000;
    localparam logic [11:0] C_LOAD  = 12'b1001_00_100000;
    localparam logic [11:0] C_STORE = 12'b0101_00_000000;
    localparam logic [11:0] C_J     = 12'b0000_00_010000;
    localparam logic [11:0] C_JAL   = 12'b0000_10_110010;
    localparam logic [11:0] C_BR    = 12'b0010_00_000000;
    localparam logic [11:0] C_BRAL  = 12'b0010_10_100010;
    localparam logic [11:0] C_MTC0  = 12'b0000_00_000001;
    localparam logic [11:0] C_MFC0  = 12'b0000_00_100000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic        invalid;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_r;
    logic          full, empty, push, pop;
    logic [11:0]   new_ctrl;
    logic          new_invalid;
    logic [5:0]    op, funct;
    logic [4:0]    rs, rt;
    entry_t        head;

    assign op    = q.inst[31:26];
    assign rs    = q.inst[25:21];
    assign rt    = q.inst[20:16];
    assign funct = q.inst[5:0];

    always_comb begin
        new_ctrl    = '0;
        new_invalid = 1'b0;
        unique case (op)
            6'h00: begin
                unique case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b:              new_ctrl = C_RALU;
                    6'h10, 6'h12: begin
                        if (ENABLE_HILO) new_ctrl    = C_RALU;
                        else             new_invalid = 1'b1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (ENABLE_HILO) new_ctrl    = C_HILO;
                        else             new_invalid = 1'b1;
                    end
                    6'h08:        new_ctrl = C_JR;
                    6'h09:        new_ctrl = C_JALR;
                    6'h0c, 6'h0d: new_ctrl = '0;
                    default:      new_invalid = 1'b1;
                endcase
            end
            6'h01: begin
                unique case (rt)
                    5'b00000, 5'b00001: new_ctrl = C_BR;
                    5'b10000, 5'b10001: new_ctrl = C_BRAL;
                    default:            new_invalid = 1'b1;
                endcase
            end
            6'h02:                                    new_ctrl = C_J;
            6'h03:                                    new_ctrl = C_JAL;
            6'h04, 6'h05, 6'h06, 6'h07:               new_ctrl = C_BR;
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f:               new_ctrl = C_IALU;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:        new_ctrl = C_LOAD;
            6'h28, 6'h29, 6'h2b:                      new_ctrl = C_STORE;
            6'h10: begin
                if (!ENABLE_CP0) begin
                    new_invalid = 1'b1;
                end else begin
                    unique case (rs)
                        5'b00100: new_ctrl = C_MTC0;
                        5'b00000: new_ctrl = C_MFC0;
                        5'b10000: new_ctrl = '0;
                        default:  new_invalid = 1'b1;
                    endcase
                end
            end
            default: new_invalid = 1'b1;
        endcase
    end

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == '0);
    assign push  = q.inst_valid && !full && !q.flush;
    assign pop   = !empty && q.dec_ready && !q.flush;

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{inst: q.inst, pc: q.inst_pc, ctrl: new_ctrl, invalid: new_invalid};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign q.inst_ready  = !full;
    assign q.dec_valid   = !empty;
    assign q.count       = count_r;
    assign q.dec_inst    = empty ? '0 : head.inst;
    assign q.dec_pc      = empty ? '0 : head.pc;
    assign q.dec_ctrl    = empty ? '0 : head.ctrl;
    assign q.dec_invalid = empty ? 1'b0 : head.invalid;
endmodule

// File: tb/tb_decode_queue.sv
// Two queues (full-featured and CP0/HILO-disabled) driven in lockstep and checked each cycle
// against a queue-based reference and a table-style decoder.
module tb_decode_queue;
    localparam int DEPTH = 4;

    localparam logic [11:0] C_RALU  = 12'b0000_01_100000;
    localparam logic [11:0] C_HILO  = 12'b0000_00_001000;
    localparam logic [11:0] C_JR    = 12'b0000_00_000100;
    localparam logic [11:0] C_JALR  = 12'b0000_01_100110;
    localparam logic [11:0] C_IALU  = 12'b0001_00_100000;
    localparam logic [11:0] C_LOAD  = 12'b1001_00_100000;
    localparam logic [11:0] C_STORE = 12'b0101_00_000000;
    localparam logic [11:0] C_J     = 12'b0000_00_010000;
    localparam logic [11:0] C_JAL   = 12'b0000_10_110010;
    localparam logic [11:0] C_BR    = 12'b0010_00_000000;
    localparam logic [11:0] C_BRAL  = 12'b0010_10_100010;
    localparam logic [11:0] C_MTC0  = 12'b0000_00_000001;
    localparam logic [11:0] C_MFC0  = 12'b0000_00_100000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic        inv;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;
    ent_t ma[$];
    ent_t mb[$];

    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH)) qa ();
    decode_queue_if #(.DEPTH(DEPTH)) qb ();

    decode_queue #(.DEPTH(DEPTH), .ENABLE_CP0(1'b1), .ENABLE_HILO(1'b1))
        dut_a (.clk(clk), .resetn(resetn), .q(qa));
    decode_queue #(.DEPTH(DEPTH), .ENABLE_CP0(1'b0), .ENABLE_HILO(1'b0))
        dut_b (.clk(clk), .resetn(resetn), .q(qb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: instruction classes by mnemonic, returns {ctrl, invalid}.
    function automatic logic [12:0] ref_decode(input logic [31:0] w, input bit cp0, input bit hilo);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                           6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b})
                return {C_RALU, 1'b0};
            if (fn inside {6'h10, 6'h12})
                return hilo ? {C_RALU, 1'b0} : {12'h000, 1'b1};
            if (fn inside {6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b})
                return hilo ? {C_HILO, 1'b0} : {12'h000, 1'b1};
            if (fn == 6'h08) return {C_JR, 1'b0};
            if (fn == 6'h09) return {C_JALR, 1'b0};
            if (fn inside {6'h0c, 6'h0d}) return 13'h0;
            return {12'h000, 1'b1};
        end
        if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01}) return {C_BR, 1'b0};
            if (rt inside {5'h10, 5'h11}) return {C_BRAL, 1'b0};
            return {12'h000, 1'b1};
        end
        if (op == 6'h10) begin
            if (!cp0) return {12'h000, 1'b1};
            if (rs == 5'h04) return {C_MTC0, 1'b0};
            if (rs == 5'h00) return {C_MFC0, 1'b0};
            if (rs == 5'h10) return 13'h0;
            return {12'h000, 1'b1};
        end
        if (op == 6'h02) return {C_J, 1'b0};
        if (op == 6'h03) return {C_JAL, 1'b0};
        if (op inside {[6'h04:6'h07]}) return {C_BR, 1'b0};
        if (op inside {[6'h08:6'h0f]}) return {C_IALU, 1'b0};
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return {C_LOAD, 1'b0};
        if (op inside {6'h28, 6'h29, 6'h2b}) return {C_STORE, 1'b0};
        return {12'h000, 1'b1};
    endfunction

    task automatic check_side(input string p, input logic v, input logic r, input logic [31:0] cnt,
                              input logic [31:0] di, input logic [31:0] dp, input logic [11:0] dc,
                              input logic dinv, input int sz, input ent_t h);
        check({p, "_valid"}, v, sz > 0);
        check({p, "_ready"}, r, sz < DEPTH);
        check({p, "_count"}, cnt, sz);
        check({p, "_inst"}, di, h.inst);
        check({p, "_pc"}, dp, h.pc);
        check({p, "_ctrl"}, dc, h.ctrl);
        check({p, "_invalid"}, dinv, h.inv);
    endtask

    task automatic check_all();
        ent_t ha;
        ent_t hb;
        ha = (ma.size() > 0) ? ma[0] : '0;
        hb = (mb.size() > 0) ? mb[0] : '0;
        check_side("a", qa.dec_valid, qa.inst_ready, 32'(qa.count), qa.dec_inst, qa.dec_pc,
                   qa.dec_ctrl, qa.dec_invalid, ma.size(), ha);
        check_side("b", qb.dec_valid, qb.inst_ready, 32'(qb.count), qb.dec_inst, qb.dec_pc,
                   qb.dec_ctrl, qb.dec_invalid, mb.size(), hb);
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        qa.inst_valid = v;  qb.inst_valid = v;
        qa.inst = w;        qb.inst = w;
        qa.inst_pc = pc;    qb.inst_pc = pc;
        qa.dec_ready = rdy; qb.dec_ready = rdy;
        qa.flush = fl;      qb.flush = fl;
    endtask

    // One clock: check current state at negedge, drive, predict, advance model at posedge.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        bit   pa, pb, oa, ob;
        ent_t ea, eb;
        @(negedge clk);
        check_all();
        drive(v, w, pc, rdy, fl);
        pa = v && (ma.size() < DEPTH) && !fl;
        pb = v && (mb.size() < DEPTH) && !fl;
        oa = (ma.size() > 0) && rdy && !fl;
        ob = (mb.size() > 0) && rdy && !fl;
        {ea.ctrl, ea.inv} = ref_decode(w, 1'b1, 1'b1);
        {eb.ctrl, eb.inv} = ref_decode(w, 1'b0, 1'b0);
        ea.inst = w; ea.pc = pc; eb.inst = w; eb.pc = pc;
        @(posedge clk);
        if (fl) begin
            ma.delete();
            mb.delete();
        end else begin
            if (oa) void'(ma.pop_front());
            if (ob) void'(mb.pop_front());
            if (pa) ma.push_back(ea);
            if (pb) mb.push_back(eb);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    logic [5:0] ops [12] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0f, 6'h10,
                             6'h20, 6'h23, 6'h2b, 6'h29};
    logic [4:0] cp0_rs [4] = '{5'h00, 5'h04, 5'h10, 5'h01};

    initial begin
        logic [31:0] w;
        logic [31:0] pc;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        resetn = 1'b0;
        #12;
        check("rst_valid", qa.dec_valid, 1'b0);
        check("rst_ready", qa.inst_ready, 1'b1);
        check("rst_count", 32'(qa.count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // ADD visible right after its push edge
        step(1'b1, 32'h00851020, 32'h100, 1'b0, 1'b0);
        #1;
        check("add_valid", qa.dec_valid, 1'b1);
        check("add_ctrl", qa.dec_ctrl, 12'b0000_01_100000);
        check("add_invalid", qa.dec_invalid, 1'b0);
        check("add_count", 32'(qa.count), 32'd1);
        drain();

        // LW, JAL, BGEZAL held then popped in order
        step(1'b1, 32'h8C820004, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h0C000010, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h04110003, 32'h208, 1'b0, 1'b0);
        #1;
        check("hold_count", 32'(qa.count), 32'd3);
        check("pop0_ctrl", qa.dec_ctrl, 12'b1001_00_100000);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("pop1_ctrl", qa.dec_ctrl, 12'b0000_10_110010);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("pop2_ctrl", qa.dec_ctrl, 12'b0010_10_100010);
        drain();

        // Fill, push+pop while full, then stream through pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h00A62021, 32'h300 + 4 * i, 1'b0, 1'b0);
        #1;
        check("full_ready", qa.inst_ready, 1'b0);
        step(1'b1, 32'h00A62021, 32'h310, 1'b1, 1'b0);
        #1;
        check("full_pop_count", 32'(qa.count), 32'd3);
        check("full_pop_ready", qa.inst_ready, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h00A62021, 32'h400 + 4 * i, 1'(i % 3 != 0), 1'b0);
        drain();

        // Reserved encodings
        step(1'b1, 32'h7C000000, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h04050000, 32'h504, 1'b0, 1'b0);
        #1;
        check("rsv_invalid", qa.dec_invalid, 1'b1);
        check("rsv_ctrl", qa.dec_ctrl, 12'h000);
        drain();

        // CP0 enabled vs disabled
        step(1'b1, 32'h42000018, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'h40820000, 32'h604, 1'b0, 1'b0);
        #1;
        check("eret_a_invalid", qa.dec_invalid, 1'b0);
        check("eret_a_ctrl", qa.dec_ctrl, 12'h000);
        check("eret_b_invalid", qb.dec_invalid, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("mtc0_a_ctrl", qa.dec_ctrl, 12'b0000_00_000001);
        check("mtc0_b_invalid", qb.dec_invalid, 1'b1);
        drain();

        // Flush beats simultaneous push and pop
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8C820004, 32'h700 + 4 * i, 1'b0, 1'b0);
        step(1'b1, 32'h00851020, 32'h70C, 1'b1, 1'b1);
        #1;
        check("flush_count", 32'(qa.count), 32'd0);
        check("flush_valid", qa.dec_valid, 1'b0);

        // Async reset mid-stream
        step(1'b1, 32'h00851020, 32'h800, 1'b0, 1'b0);
        step(1'b1, 32'h00851020, 32'h804, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("arst_a_valid", qa.dec_valid, 1'b0);
        check("arst_b_valid", qb.dec_valid, 1'b0);
        check("arst_count", 32'(qa.count), 32'd0);
        ma.delete();
        mb.delete();
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: w[31:26] = 6'h00;
                2: w[31:26] = ops[$urandom_range(0, 11)];
                default: begin
                    w[31:26] = 6'h10;
                    w[25:21] = cp0_rs[$urandom_range(0, 3)];
                end
            endcase
            step(1'($urandom_range(0, 3) != 0), w, pc, 1'($urandom_range(0, 4) < 3),
                 1'($urandom_range(0, 39) == 0));
            pc = pc + 32'd4;
        end
        @(negedge clk);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, parametrised successor to the combinational main decoder in the MIPS core.
- Accepts fetched instructions over a valid/ready handshake and decodes op/funct/rs/rt into the 12-bit control word plus a reserved-instruction flag at enqueue time.
- Stores instruction, PC, controls and flag in a DEPTH-entry FIFO and presents them in order to the ID/EX boundary.
- Decouples fetch from stalls; supports pipeline flush on exception or branch redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ENABLE_CP0, 1, if 0 then MTC0/MFC0/ERET decode as reserved.
- ENABLE_HILO, 1, if 0 then MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO decode as reserved.

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all entries and any same-cycle push
- inst_valid  in  1  fetch offers an instruction
- inst_ready  out  1  queue accepts; equals !full
- inst  in  32  instruction word
- inst_pc  in  32  instruction PC
- dec_valid  out  1  head entry valid; equals !empty
- dec_ready  in  1  decode stage consumes head
- dec_inst  out  32  head instruction
- dec_pc  out  32  head PC
- dec_ctrl  out  12  {memtoreg,memwrite,branch,alusrc,regdst[1:0],regwrite,jump,hilo_write,jr,jal,cp0_write}
- dec_invalid  out  1  head is a reserved instruction
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, resetn=0):
  - read/write pointers and count go to 0; dec_valid=0; inst_ready=1.
  - dec_inst, dec_pc, dec_ctrl and dec_invalid drive 0 while empty; storage need not be cleared.
- Handshakes:
  - Push when inst_valid && inst_ready.
  - Pop when dec_valid && dec_ready.
  - Head outputs are stable while dec_valid=1 && dec_ready=0.
- Latency: an instruction pushed at edge t is visible on dec_* after edge t; no same-cycle bypass when empty.
- Full: inst_ready=0. A pop in the same cycle does not enable a push; push resumes next cycle.
- Empty: dec_valid=0; dec_ready is ignored.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.
- flush=1 at an edge:
  - count and pointers go to 0; same-cycle push and pop are discarded.
  - flush takes priority over every other event.
  - dec_valid=0 next cycle.
- Decode (combinational on inst, registered into the FIFO). op=inst[31:26], rs=[25:21], rt=[20:16], funct=[5:0]:
  - R-type (op 000000):
    - AND/OR/XOR/NOR, shifts, ADD/ADDU/SUB/SUBU/SLT/SLTU, MFHI/MFLO -> 0000_01_100000
    - MULT/MULTU/DIV/DIVU/MTHI/MTLO -> 0000_00_001000
    - JR -> 0000_00_000100
    - JALR -> 0000_01_100110
    - SYSCALL/BREAK -> 0
    - other funct -> 0, invalid
  - I-type:
    - ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU -> 0001_00_100000
    - loads LB/LBU/LH/LHU/LW -> 1001_00_100000
    - stores SB/SH/SW -> 0101_00_000000
  - Jumps: J -> 0000_00_010000; JAL -> 0000_10_110010.
  - Branches:
    - BEQ/BNE/BGTZ/BLEZ -> 0010_00_000000
    - REGIMM (op 000001), by rt: BLTZ/BGEZ -> 0010_00_000000; BLTZAL/BGEZAL -> 0010_10_100010; other rt -> invalid
  - COP0 (op 010000), by rs:
    - MTC0 (00100) -> 0000_00_000001
    - MFC0 (00000) -> 0000_00_100000
    - ERET (10000) -> 0
    - other rs -> invalid
  - Any other op -> 0, invalid.
  - Parameter-disabled classes -> 0, invalid.
- An invalid entry is still queued; the exception is raised downstream.
- Reset asserted mid-stream: contents are lost immediately; no partial entry survives.

Test Plan:
- Reset, then push 0x00851020 (ADD) at t -> dec_valid=1 after edge t, dec_ctrl=0000_01_100000, dec_invalid=0, count=1.
- Push LW 0x8C820004, JAL 0x0C000010, BGEZAL 0x04110003 with dec_ready=0 -> count=3; pop order and ctrls 1001_00_100000, 0000_10_110010, 0010_10_100010.
- DEPTH=4: fill 4 -> inst_ready=0; push+pop same cycle -> count 3, then accepts; run 10 entries to exercise pointer wrap with in-order PCs.
- Push 0x7C000000 and REGIMM rt=00101 -> dec_invalid=1, dec_ctrl=0.
- ENABLE_CP0=0: ERET 0x42000018 and MTC0 0x40820000 -> invalid. ENABLE_CP0=1: ctrl 0 and 0000_00_000001, invalid=0.
- count=3 with flush, inst_valid and dec_ready all 1 -> count=0 and dec_valid=0 next cycle. Assert resetn=0 asynchronously mid-stream -> dec_valid falls before the next clk edge.
